// File: rtl/perfect_scan_seq.sv
// Scan sequencer: steps N from lo to hi, launches one perfect-number check per
// value, and buffers every N the checker reports as perfect.
module perfect_scan_seq #(
  parameter int unsigned W        = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [W-1:0]             lo,
  input  logic [W-1:0]             hi,
  output logic [W-1:0]             chk_n,
  output logic                     chk_go,
  input  logic                     chk_over,
  input  logic                     chk_isper,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   found_cnt,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [W-1:0]             rd_data
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_GAP, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_cur;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_chk_n;
  logic           r_go;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic           r_ovf;
  logic [AW:0]    r_cnt;
  logic [WCW-1:0] r_wcnt;
  logic [W-1:0]   r_buf [DEPTH];

  logic w_accept;
  logic w_timeout;
  logic w_go_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_timeout = (r_state == S_WAIT) && !chk_over &&
                     (r_wcnt == WCW'(MAX_WAIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = (lo > hi) ? S_DONE : S_LAUNCH;
      S_LAUNCH:       w_state_nxt = S_GAP;
      S_GAP:          w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (chk_over)       w_state_nxt = S_NEXT;
        else if (w_timeout) w_state_nxt = S_DONE;
      end
      S_NEXT:         w_state_nxt = (r_cur == r_hi) ? S_DONE : S_LAUNCH;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the status outputs are registered
  always_comb begin
    w_go_nxt   = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_LAUNCH:            begin w_go_nxt = 1'b1; w_busy_nxt = 1'b1; end
      S_GAP, S_WAIT, S_NEXT: w_busy_nxt = 1'b1;
      S_DONE:              w_done_nxt = 1'b1;
      default:             ;
    endcase
  end

  // Datapath: candidate, wait counter, verdict capture and result buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur   <= '0;
      r_hi    <= '0;
      r_chk_n <= '0;
      r_go    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_go   <= w_go_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_hi  <= hi;
        r_err <= 1'b0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
        if (lo <= hi) begin
          r_cur   <= lo;
          r_chk_n <= lo;
        end
      end
      if (r_state == S_GAP) r_wcnt <= '0;
      if (r_state == S_WAIT) begin
        if (chk_over) begin
          if (chk_isper) begin
            if (r_cnt < (AW+1)'(DEPTH)) begin
              r_buf[r_cnt[AW-1:0]] <= r_cur;
              r_cnt                <= r_cnt + (AW+1)'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end else begin
          r_wcnt <= r_wcnt + WCW'(1);
          if (w_timeout) r_err <= 1'b1;
        end
      end
      // Compare before increment so hi = all-ones never wraps
      if ((r_state == S_NEXT) && (r_cur != r_hi)) begin
        r_cur   <= r_cur + W'(1);
        r_chk_n <= r_cur + W'(1);
      end
    end
  end

  assign chk_n     = r_chk_n;
  assign chk_go    = r_go;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign ovf       = r_ovf;
  assign found_cnt = r_cnt;
  assign rd_data   = r_buf[rd_idx];

endmodule

// File: tb/tb_perfect_scan_seq.sv
// Randomized self-checking bench for perfect_scan_seq with a behavioural
// checker model and a range-based reference for the expected scan results.
module tb_perfect_scan_seq;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned MAXW  = 15;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] lo, hi, chk_n, rd_data;
  logic         chk_go, chk_over, chk_isper, busy, done, err, ovf;
  logic [1:0]   found_cnt;
  logic [0:0]   rd_idx;

  perfect_scan_seq #(.W(W), .DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
    .chk_n(chk_n), .chk_go(chk_go), .chk_over(chk_over), .chk_isper(chk_isper),
    .busy(busy), .done(done), .err(err), .ovf(ovf), .found_cnt(found_cnt),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int tcyc = 0, last_go = 0, go_cnt = 0, seq_bad = 0, gap_bad = 0;
  int mon_base = 0, mon_m = 5, mode_r = 0, dly = 6, m_cnt = 0, m_n = 0;
  bit clr_pend = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit ref_perfect(input int mode, input int n);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return (n == 6) || (n == 28) || (n == 496) || (n == 8128);
  endfunction

  // Checker model: over rises (m+1) negedges after go, clears one cycle after go
  always @(negedge clk) begin
    tcyc++;
    if (clr_pend) begin chk_over = 1'b0; chk_isper = 1'b0; clr_pend = 0; end
    if (chk_go) begin
      if (chk_n !== 16'(mon_base + go_cnt)) seq_bad++;
      if (go_cnt > 0 && (tcyc - last_go) != mon_m + 3) gap_bad++;
      last_go  = tcyc;
      go_cnt++;
      m_n      = int'(chk_n);
      clr_pend = 1;
      m_cnt    = (mode_r == 2) ? 0 : dly;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        chk_over  = 1'b1;
        chk_isper = ref_perfect(mode_r, m_n);
      end
    end
  end

  task automatic run_scan(input int lo_v, input int hi_v, input int mode, input int m);
    int cyc, n_cand, k, exp_go, exp_cyc, exp_cnt, exp_nfin;
    int found[$];
    logic [W-1:0] prev_n;
    @(negedge clk);
    mode_r = mode; dly = m + 1; mon_m = m; mon_base = lo_v;
    go_cnt = 0; seq_bad = 0; gap_bad = 0;
    prev_n = chk_n;
    start = 1'b1; lo = W'(lo_v); hi = W'(hi_v);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
    n_cand = (lo_v > hi_v) ? 0 : hi_v - lo_v + 1;
    for (int v = lo_v; v <= hi_v; v++) if (ref_perfect(mode, v)) found.push_back(v);
    k = found.size();
    if (mode == 2 && n_cand > 0) begin
      exp_go = 1; exp_cyc = 3 + MAXW; exp_nfin = lo_v;
    end else begin
      exp_go = n_cand; exp_cyc = 1 + n_cand * (m + 3);
      exp_nfin = (n_cand > 0) ? hi_v : int'(prev_n);
    end
    exp_cnt = (k > DEPTH) ? DEPTH : k;
    check("done", 32'(done), 1);
    check("done_latency", 32'(cyc), 32'(exp_cyc));
    check("busy_at_done", 32'(busy), 0);
    check("err", 32'(err), 32'(mode == 2 && n_cand > 0));
    check("ovf", 32'(ovf), 32'(k > DEPTH));
    check("found_cnt", 32'(found_cnt), 32'(exp_cnt));
    check("chk_n_final", 32'(chk_n), 32'(exp_nfin));
    check("go_seq", 32'(seq_bad), 0);
    check("go_spacing", 32'(gap_bad), 0);
    for (int i = 0; i < exp_cnt; i++) begin
      rd_idx = 1'(i);
      #1;
      check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(found[i]));
    end
    repeat (5) @(negedge clk);
    check("go_count", 32'(go_cnt), 32'(exp_go));
    check("done_held", 32'(done), 1);
  endtask

  initial begin
    int lo_v, hi_v, p, cyc;
    int plist[5] = '{6, 28, 496, 8128, 65530};
    rst = 1'b1; start = 1'b0; lo = '0; hi = '0; rd_idx = '0;
    chk_over = 1'b0; chk_isper = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_chk_n", 32'(chk_n), 0);
    check("rst_go", 32'(chk_go), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_found", 32'(found_cnt), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;

    run_scan(1, 30, 0, 5);
    run_scan(10, 5, 0, 5);
    run_scan(496, 496, 0, 5);
    run_scan(65535, 65535, 0, 5);
    run_scan(1, 4, 1, 5);
    run_scan(6, 6, 2, 5);
    run_scan(5, 500, 0, 1);

    for (int it = 0; it < 8; it++) begin
      p    = plist[$urandom_range(0, 4)];
      lo_v = p - int'($urandom_range(0, 6));
      hi_v = lo_v + int'($urandom_range(0, 12));
      if (hi_v > 65535) hi_v = 65535;
      if ($urandom_range(0, 5) == 0) begin int t = lo_v; lo_v = hi_v + 1; hi_v = t; end
      if (lo_v > 65535) lo_v = 65535;
      run_scan(lo_v, hi_v, int'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
    end

    // Reset in the middle of a scan
    @(negedge clk);
    mode_r = 0; dly = 6; mon_m = 5; mon_base = 1;
    start = 1'b1; lo = 16'd1; hi = 16'd100;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (chk_n != 16'd20 && cyc < 1000) begin @(negedge clk); cyc++; end
    check("reach_n20", 32'(chk_n), 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    go_cnt = 0;
    rd_idx = 1'b0;
    check("mid_rst_chk_n", 32'(chk_n), 0);
    check("mid_rst_go", 32'(chk_go), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    check("mid_rst_found", 32'(found_cnt), 0);
    check("mid_rst_rd_data", 32'(rd_data), 0);
    repeat (20) @(negedge clk);
    check("post_rst_no_go", 32'(go_cnt), 0);
    run_scan(1, 30, 0, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
